// File: rtl/cmd_rst_decoder.sv
// Command-stream receiver: reset-code words become a fixed-length reset pulse plus hold-off; other words go through a 1-deep output slot.
// Latency 1 cycle accept-to-output; input stalls while the output slot is full and not draining, and during pulse/hold-off.
module cmd_rst_decoder #(
    parameter logic [31:0] RST_CODE    = 32'hF000_0000,
    parameter logic [31:0] RST_MASK    = 32'hFFFF_FFFF,
    parameter int          RST_LEN     = 16,
    parameter int          HOLDOFF_LEN = 4,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_in_valid,
    output logic             cmd_in_ready,
    input  logic [31:0]      cmd_in,
    input  logic             cmd_out_ready,
    output logic             cmd_out_valid,
    output logic [31:0]      cmd_out,
    output logic             rst_out,
    output logic [CNT_W-1:0] rst_count,
    output logic             busy
);

    localparam int MAX_LEN = (RST_LEN > HOLDOFF_LEN) ? RST_LEN : HOLDOFF_LEN;
    localparam int CTR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CTR_W-1:0] PULSE_LOAD = CTR_W'(RST_LEN - 1);
    localparam logic [CTR_W-1:0] HOLD_LOAD  = CTR_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);
    localparam logic             HAS_HOLD   = (HOLDOFF_LEN > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic             rst_out_q, rst_out_d;
    logic [CNT_W-1:0] rst_count_q, rst_count_d;
    logic             cmd_out_valid_q, cmd_out_valid_d;
    logic [31:0]      cmd_out_q, cmd_out_d;
    logic             accept;
    logic             match;

    // A reset code only enters when the slot is empty or draining, so no word is stranded behind a pulse.
    assign cmd_in_ready = (state_q == IDLE) & (~cmd_out_valid_q | cmd_out_ready);
    assign accept       = cmd_in_valid & cmd_in_ready;
    assign match        = ((cmd_in ^ RST_CODE) & RST_MASK) == 32'd0;

    always_comb begin
        state_d         = state_q;
        ctr_d           = ctr_q;
        rst_out_d       = rst_out_q;
        rst_count_d     = rst_count_q;
        cmd_out_valid_d = cmd_out_valid_q;
        cmd_out_d       = cmd_out_q;

        if (cmd_out_valid_q & cmd_out_ready) begin
            cmd_out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept & match) begin
                    state_d   = PULSE;
                    ctr_d     = PULSE_LOAD;
                    rst_out_d = 1'b1;
                    if (rst_count_q != {CNT_W{1'b1}}) begin
                        rst_count_d = rst_count_q + 1'b1;
                    end
                end else if (accept) begin
                    cmd_out_valid_d = 1'b1;
                    cmd_out_d       = cmd_in;
                end
            end
            PULSE: begin
                if (ctr_q == '0) begin
                    rst_out_d = 1'b0;
                    if (HAS_HOLD) begin
                        state_d = HOLDOFF;
                        ctr_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            HOLDOFF: begin
                if (ctr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                rst_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            ctr_q           <= '0;
            rst_out_q       <= 1'b0;
            rst_count_q     <= '0;
            cmd_out_valid_q <= 1'b0;
            cmd_out_q       <= 32'd0;
        end else begin
            state_q         <= state_d;
            ctr_q           <= ctr_d;
            rst_out_q       <= rst_out_d;
            rst_count_q     <= rst_count_d;
            cmd_out_valid_q <= cmd_out_valid_d;
            cmd_out_q       <= cmd_out_d;
        end
    end

    assign cmd_out_valid = cmd_out_valid_q;
    assign cmd_out       = cmd_out_q;
    assign rst_out       = rst_out_q;
    assign rst_count     = rst_count_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_rst_decoder.sv
// Bench for cmd_rst_decoder: default instance (a_*) and a masked, 2-bit-counter, no-hold-off instance (b_*).
module tb_cmd_rst_decoder;

    localparam int A_LEN  = 16;
    localparam int A_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_ready, a_out_valid, a_rst_out, a_busy;
    logic [31:0] a_cmd_in, a_cmd_out;
    logic [7:0]  a_count;

    logic        b_in_valid, b_in_ready, b_out_ready, b_out_valid, b_rst_out, b_busy;
    logic [31:0] b_cmd_in, b_cmd_out;
    logic [1:0]  b_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cmd_rst_decoder u_a (
        .clk(clk), .rst(rst),
        .cmd_in_valid(a_in_valid), .cmd_in_ready(a_in_ready), .cmd_in(a_cmd_in),
        .cmd_out_ready(a_out_ready), .cmd_out_valid(a_out_valid), .cmd_out(a_cmd_out),
        .rst_out(a_rst_out), .rst_count(a_count), .busy(a_busy)
    );

    cmd_rst_decoder #(
        .RST_CODE(32'hF000_0000), .RST_MASK(32'hF000_0000),
        .RST_LEN(3), .HOLDOFF_LEN(0), .CNT_W(2)
    ) u_b (
        .clk(clk), .rst(rst),
        .cmd_in_valid(b_in_valid), .cmd_in_ready(b_in_ready), .cmd_in(b_cmd_in),
        .cmd_out_ready(b_out_ready), .cmd_out_valid(b_out_valid), .cmd_out(b_cmd_out),
        .rst_out(b_rst_out), .rst_count(b_count), .busy(b_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] cmd;
        logic        v;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_out;
    } vec_t;

    vec_t vecs[12];

    // Reference model state for the random phase: cycles since the last reset-code accept,
    // total reset codes accepted, and the contents of the one-word output slot.
    int          m_since;
    int          m_cnt;
    logic        m_ov;
    logic [31:0] m_word;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nacc;
        logic exp_busy, exp_rst, exp_rdy, acc, is_code;

        vecs[0]  = '{32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678};
        vecs[2]  = '{32'hAAAA_5555, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0001};
        vecs[3]  = '{32'h0FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_5555};
        vecs[4]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0FFF_FFFF};
        vecs[5]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFF};
        vecs[6]  = '{32'h0000_0011, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFF};
        vecs[7]  = '{32'h0000_0022, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0011};
        vecs[8]  = '{32'h0000_0022, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0011};
        vecs[9]  = '{32'h0000_0022, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0011};
        vecs[10] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0022};
        vecs[11] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0022};

        rst = 1'b1;
        a_in_valid = 1'b0; a_cmd_in = 32'd0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_cmd_in = 32'd0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rst_out", a_rst_out, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_cmd_out", a_cmd_out, 0);
        chk("rst_count", a_count, 0);
        chk("rst_busy", a_busy, 0);

        // Idle after release
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", a_in_ready, 1);
        chk("idle_rst_out", a_rst_out, 0);
        chk("idle_out_valid", a_out_valid, 0);
        chk("idle_busy", a_busy, 0);

        // Streaming and backpressure vectors
        for (int i = 0; i < 12; i++) begin
            a_cmd_in = vecs[i].cmd; a_in_valid = vecs[i].v; a_out_ready = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), a_in_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_out_valid", i), a_out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d_cmd_out", i), a_cmd_out, vecs[i].e_out);
            @(posedge clk); #1;
        end

        // Reset code, with a second code held on the input through pulse and hold-off
        a_in_valid = 1'b1; a_cmd_in = 32'hF000_0000; a_out_ready = 1'b1;
        @(negedge clk);
        chk("pulse_acc_ready", a_in_ready, 1);
        @(posedge clk); #1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            chk($sformatf("pulse_k%0d_rst_out", k), a_rst_out, ((k <= A_LEN) || (k >= A_LEN + A_HOLD + 2)) ? 1 : 0);
            chk($sformatf("pulse_k%0d_ready", k), a_in_ready, (k == A_LEN + A_HOLD + 1) ? 1 : 0);
            chk($sformatf("pulse_k%0d_out_valid", k), a_out_valid, 0);
            chk($sformatf("pulse_k%0d_count", k), a_count, (k >= A_LEN + A_HOLD + 2) ? 2 : 1);
            @(posedge clk); #1;
            if (k == A_LEN + A_HOLD + 1) a_in_valid = 1'b0;
        end
        for (int n = 0; n < 40 && a_busy; n++) begin
            @(posedge clk); #1;
        end
        chk("pulse2_done_busy", a_busy, 0);

        // Asynchronous reset in the middle of a pulse
        a_in_valid = 1'b1; a_cmd_in = 32'hF000_0000;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_pre_rst_out", a_rst_out, 1);
        rst = 1'b1;
        #1;
        chk("abort_rst_out", a_rst_out, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_count", a_count, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_post_ready", a_in_ready, 1);
        chk("abort_post_busy", a_busy, 0);
        chk("abort_post_count", a_count, 0);

        // Masked match, no hold-off, saturating 2-bit count
        b_in_valid = 1'b1; b_cmd_in = 32'hF123_4567; b_out_ready = 1'b1;
        @(negedge clk);
        chk("b_acc_ready", b_in_ready, 1);
        @(posedge clk); #1;
        b_cmd_in = 32'hF555_5555;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("b_k%0d_rst_out", k), b_rst_out, (k <= 3) ? 1 : 0);
            chk($sformatf("b_k%0d_ready", k), b_in_ready, (k == 4) ? 1 : 0);
            @(posedge clk); #1;
        end
        nacc = 2;
        for (int n = 0; n < 100 && nacc < 5; n++) begin
            @(negedge clk);
            if (b_in_ready) nacc++;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        chk("b_accepts", nacc, 5);
        for (int n = 0; n < 20 && b_busy; n++) begin
            @(posedge clk); #1;
        end
        chk("b_done_busy", b_busy, 0);
        chk("b_count_sat", b_count, 3);
        b_in_valid = 1'b1; b_cmd_in = 32'hE000_0000;
        @(negedge clk);
        chk("b_fwd_ready", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("b_fwd_valid", b_out_valid, 1);
        chk("b_fwd_cmd_out", b_cmd_out, 32'hE000_0000);
        chk("b_fwd_rst_out", b_rst_out, 0);
        chk("b_fwd_count", b_count, 3);

        // Randomized traffic against the reference model
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        m_since = 1000; m_cnt = 0; m_ov = 1'b0; m_word = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            a_in_valid  = ($urandom_range(0, 1) == 1);
            a_out_ready = ($urandom_range(0, 9) < 7);
            a_cmd_in    = ($urandom_range(0, 7) == 0) ? 32'hF000_0000 : $urandom;
            @(negedge clk);
            exp_rst  = (m_since >= 1) && (m_since <= A_LEN);
            exp_busy = (m_since >= 1) && (m_since <= A_LEN + A_HOLD);
            exp_rdy  = !exp_busy && (!m_ov || a_out_ready);
            chk("rnd_rst_out", a_rst_out, exp_rst);
            chk("rnd_busy", a_busy, exp_busy);
            chk("rnd_ready", a_in_ready, exp_rdy);
            chk("rnd_out_valid", a_out_valid, m_ov);
            if (m_ov) chk("rnd_cmd_out", a_cmd_out, m_word);
            chk("rnd_count", a_count, (m_cnt > 255) ? 255 : m_cnt);
            acc     = a_in_valid && exp_rdy;
            is_code = (a_cmd_in == 32'hF000_0000);
            @(posedge clk);
            m_since = (m_since >= 1000) ? 1000 : m_since + 1;
            if (m_ov && a_out_ready) m_ov = 1'b0;
            if (acc && is_code) begin
                m_since = 1;
                m_cnt++;
            end else if (acc) begin
                m_ov   = 1'b1;
                m_word = a_cmd_in;
            end
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
